video_pattern_compositor: RTL
=============================

Name: video_pattern_compositor

Overview:
- Pixel-clock-domain block between the video timing generator and the DVI/HDMI transmitter.
- Generates one of four selectable test patterns and composites it with RGB565 camera data from the frame-buffer read path, using a programmable horizontal or vertical split.
- Control inputs are shadowed at frame boundaries, so mode changes never tear mid-frame.
- Output is registered RGB888 with delay-matched syncs.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- COORD_W, 11, width of x/y coordinates and split position
- NUM_BARS, 16, colour-bar count; H_ACTIVE must be divisible by NUM_BARS
- CHECK_SHIFT, 5, checkerboard square size is 2^CHECK_SHIFT pixels
- SCROLL_STEP, 4, moving-bar advance in pixels per frame; must be < H_ACTIVE
- BAR_W, 32, moving-bar width in pixels

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pat_mode  in  2  0=colour bars, 1=gradient, 2=checkerboard, 3=moving bar
- split_dir  in  1  0=split on y (camera below), 1=split on x (camera right)
- split_pos  in  COORD_W  first camera line/column
- cam_en  in  1  enable camera region; 0 = full-screen pattern
- in_hs, in_vs, in_de  in  1 each  timing from generator, active high
- in_x, in_y  in  COORD_W each  active coordinates, valid when in_de=1
- cam_r, cam_b  in  5 each; cam_g  in  6  camera pixel, cycle-aligned with in_de
- out_hs, out_vs, out_de  out  1 each  syncs delayed 2 cycles
- out_r, out_g, out_b  out  8 each  composited pixel
- frame_cnt  out  8  frames seen since reset, wraps 255->0

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst_n is asynchronous, active-low.
- Reset values:
  - All out_* = 0; frame_cnt = 0; scroll = 0.
  - Shadow registers: mode=0, dir=0, pos=V_ACTIVE/2, cam_en=0.
- Frame boundary (rising edge of in_vs, detected against a registered copy):
  - Latch pat_mode, split_dir, split_pos, cam_en into the shadow registers.
  - frame_cnt += 1.
  - scroll updates: scroll = scroll+SCROLL_STEP, minus H_ACTIVE if the result is >= H_ACTIVE.
  - All three updates take effect in the same cycle.
  - Inputs changed mid-frame have no effect until the next rising edge of in_vs.
- Colour bars:
  - No divider. A pixel-in-bar counter runs while in_de=1; bar index increments when the counter reaches H_ACTIVE/NUM_BARS-1.
  - Both counters clear whenever in_de=0.
  - Colour = bar_index mod 8, mapped to white, yellow, cyan, green, magenta, red, blue, black (0xFF/0x00 components).
- Gradient: r=in_x[7:0], g=in_y[7:0], b=frame_cnt.
- Checkerboard: white if (in_x>>CHECK_SHIFT)^(in_y>>CHECK_SHIFT) has bit0=1, else black.
- Moving bar:
  - White where scroll <= in_x < scroll+BAR_W, else black.
  - Wrap: when scroll+BAR_W > H_ACTIVE, also white where in_x < scroll+BAR_W-H_ACTIVE.
- Camera region:
  - Selected when cam_en_s=1 and (dir=0 ? in_y >= pos : in_x >= pos).
  - If pos=0, the whole frame is camera.
  - If pos >= active size, the whole frame is pattern.
- Camera expansion: r={cam_r,cam_r[4:2]}, g={cam_g,cam_g[5:4]}, b={cam_b,cam_b[4:2]}.
- Pipeline:
  - Stage 1 registers the pattern/camera select and chosen pixel.
  - Stage 2 registers the output and forces RGB=0 when the delayed de=0.
  - Total latency 2 cycles for pixel and syncs alike; no bubbles.
- Reset mid-frame: outputs go to 0 immediately. After release, output is the mode-0 pattern with camera disabled until the first in_vs rising edge.

Optional Feature:
- Macro: VIDEO_PATTERN_BORDER_EN.
- Defined: pixels with in_x==0, in_x==H_ACTIVE-1, in_y==0 or in_y==V_ACTIVE-1 are forced to white (0xFFFFFF), over both pattern and camera, with latency unchanged.
- Undefined: no border logic; output is exactly as in Behaviour.

Test Plan:
- Reset, then drive 1280x720 timing with pat_mode=0, cam_en=0 -> out_r/g/b=FFFFFF for x 0..79 and FFFF00 for x 80..159; x 560..639 black; x 640..719 white again; out_de equals in_de delayed 2 cycles.
- Set cam_en=1, split_dir=0, split_pos=360, cam pixel=16'hF800, at mid-frame -> unchanged this frame; from next frame lines 0..359 show pattern and lines 360..719 show FF0000.
- pat_mode=2, CHECK_SHIFT=5 -> (x=0,y=0) black, (x=32,y=0) white, (x=32,y=32) black.
- pat_mode=3, run 321 frames with SCROLL_STEP=4 -> scroll wraps 1276->0 at frame 320 (next frame 4); at scroll=1264 white spans x 1264..1279 and 0..15; frame_cnt reads 65 after 321 frames.
- Assert rst_n mid-line -> all outputs 0 in the same cycle; after release, colour bars with no camera until the next in_vs edge.
- With VIDEO_PATTERN_BORDER_EN and a camera full-screen (split_pos=0) -> row 0, row 719, column 0 and column 1279 are FFFFFF; all other pixels are camera data.

Source files
------------

// File: rtl/video_pattern_compositor_if.sv
// Video stream bundle for the pattern compositor.
// Carries generator timing, active coordinates and the camera pixel in,
// and the composited RGB888 pixel with its delayed syncs out.
//   in_hs/in_vs/in_de : timing from the generator, active high
//   in_x/in_y         : active coordinates, valid while in_de=1
//   cam_r/cam_g/cam_b : RGB565 camera pixel, aligned with in_de
//   out_hs/vs/de      : syncs delayed to match the pixel pipeline
//   out_r/out_g/out_b : composited RGB888 pixel
// master drives the stream in (timing side); slave is the compositor.
interface video_pattern_compositor_if #(
  parameter int unsigned COORD_W = 11
);
  logic               in_hs;
  logic               in_vs;
  logic               in_de;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic [4:0]         cam_r;
  logic [5:0]         cam_g;
  logic [4:0]         cam_b;
  logic               out_hs;
  logic               out_vs;
  logic               out_de;
  logic [7:0]         out_r;
  logic [7:0]         out_g;
  logic [7:0]         out_b;

  modport master (
    output in_hs, in_vs, in_de, in_x, in_y, cam_r, cam_g, cam_b,
    input  out_hs, out_vs, out_de, out_r, out_g, out_b
  );

  modport slave (
    input  in_hs, in_vs, in_de, in_x, in_y, cam_r, cam_g, cam_b,
    output out_hs, out_vs, out_de, out_r, out_g, out_b
  );
endinterface

// File: rtl/video_pattern_compositor.sv
// Test-pattern generator and camera compositor for the pixel-clock domain.
// Produces one of four patterns (colour bars, gradient, checkerboard,
// moving bar) and overlays RGB565 camera data beyond a horizontal or
// vertical split. Control inputs are shadowed on the rising edge of in_vs.
// Ports:
//   clk, rst_n      : pixel clock, asynchronous active-low reset
//   pat_mode        : 0 bars, 1 gradient, 2 checkerboard, 3 moving bar
//   split_dir       : 0 split on y (camera below), 1 split on x (camera right)
//   split_pos       : first camera line/column
//   cam_en          : enable camera region
//   vid             : video stream (slave modport), 2-cycle latency
//   frame_cnt       : frames seen since reset, wraps
// Optional: define VIDEO_PATTERN_BORDER_EN to force a one-pixel white
// border around the active area over both pattern and camera.
module video_pattern_compositor #(
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned V_ACTIVE    = 720,
  parameter int unsigned COORD_W     = 11,
  parameter int unsigned NUM_BARS    = 16,
  parameter int unsigned CHECK_SHIFT = 5,
  parameter int unsigned SCROLL_STEP = 4,
  parameter int unsigned BAR_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               pat_mode,
  input  logic                     split_dir,
  input  logic [COORD_W-1:0]       split_pos,
  input  logic                     cam_en,
  video_pattern_compositor_if.slave vid,
  output logic [7:0]               frame_cnt
);

  localparam int unsigned        EXT_W    = COORD_W + 1;
  localparam int unsigned        BAR_PIX  = H_ACTIVE / NUM_BARS;
  localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_PIX - 1);
  localparam logic [COORD_W-1:0] POS_RST  = COORD_W'(V_ACTIVE / 2);
  localparam logic [EXT_W-1:0]   H_EXT    = EXT_W'(H_ACTIVE);
  localparam logic [EXT_W-1:0]   STEP_EXT = EXT_W'(SCROLL_STEP);
  localparam logic [EXT_W-1:0]   BARW_EXT = EXT_W'(BAR_W);

  logic               vs_q;
  logic               vs_rise;
  logic [1:0]         mode_s;
  logic               dir_s;
  logic [COORD_W-1:0] pos_s;
  logic               cam_en_s;
  logic [COORD_W-1:0] scroll;
  logic [EXT_W-1:0]   scroll_sum;
  logic [COORD_W-1:0] scroll_nxt;
  logic [COORD_W-1:0] pix_cnt;
  logic [2:0]         bar_idx;
  logic [EXT_W-1:0]   x_ext;
  logic [EXT_W-1:0]   bar_start;
  logic [EXT_W-1:0]   bar_end;
  logic               mbar_white;
  logic               chk_white;
  logic               in_cam;
  logic [23:0]        pat_rgb;
  logic [23:0]        cam_rgb;
  logic [23:0]        pix_sel;
  logic               hs1;
  logic               vs1;
  logic               de1;
  logic [23:0]        pix1;

  assign vs_rise = vid.in_vs & ~vs_q;

  // Scroll advance with wrap back into the active width.
  assign scroll_sum = {1'b0, scroll} + STEP_EXT;
  assign scroll_nxt = (scroll_sum >= H_EXT) ? COORD_W'(scroll_sum - H_EXT)
                                            : COORD_W'(scroll_sum);

  // Frame-boundary shadowing, frame counter and scroll position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      mode_s    <= 2'd0;
      dir_s     <= 1'b0;
      pos_s     <= POS_RST;
      cam_en_s  <= 1'b0;
      frame_cnt <= 8'd0;
      scroll    <= '0;
    end else begin
      vs_q <= vid.in_vs;
      if (vs_rise) begin
        mode_s    <= pat_mode;
        dir_s     <= split_dir;
        pos_s     <= split_pos;
        cam_en_s  <= cam_en;
        frame_cnt <= frame_cnt + 8'd1;
        scroll    <= scroll_nxt;
      end
    end
  end

  // Divider-free bar tracking; only the low three bits of the bar index
  // matter because the palette repeats every eight bars.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (!vid.in_de) begin
      pix_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (pix_cnt == BAR_LAST) begin
      pix_cnt <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      pix_cnt <= pix_cnt + COORD_W'(1);
    end
  end

  // Moving bar, including the segment that wraps past the right edge.
  assign x_ext      = {1'b0, vid.in_x};
  assign bar_start  = {1'b0, scroll};
  assign bar_end    = bar_start + BARW_EXT;
  assign mbar_white = ((x_ext >= bar_start) && (x_ext < bar_end)) ||
                      ((bar_end > H_EXT) && (x_ext < (bar_end - H_EXT)));

  assign chk_white = vid.in_x[CHECK_SHIFT] ^ vid.in_y[CHECK_SHIFT];

  // Pattern pixel; bar palette bits are r=~i[1], g=~i[2], b=~i[0].
  always_comb begin
    pat_rgb = '0;
    case (mode_s)
      2'd0:    pat_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
      2'd1:    pat_rgb = {vid.in_x[7:0], vid.in_y[7:0], frame_cnt};
      2'd2:    pat_rgb = {24{chk_white}};
      default: pat_rgb = {24{mbar_white}};
    endcase
  end

  // RGB565 to RGB888 by replicating the top bits into the low bits.
  assign cam_rgb = {vid.cam_r, vid.cam_r[4:2],
                    vid.cam_g, vid.cam_g[5:4],
                    vid.cam_b, vid.cam_b[4:2]};

  assign in_cam = cam_en_s && (dir_s ? (vid.in_x >= pos_s) : (vid.in_y >= pos_s));

`ifdef VIDEO_PATTERN_BORDER_EN
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);
  logic on_border;
  assign on_border = (vid.in_x == '0) || (vid.in_x == X_LAST) ||
                     (vid.in_y == '0) || (vid.in_y == Y_LAST);
  assign pix_sel   = on_border ? 24'hFF_FFFF : (in_cam ? cam_rgb : pat_rgb);
`else
  assign pix_sel   = in_cam ? cam_rgb : pat_rgb;
`endif

  // Two-stage pixel/sync pipeline; blanking is forced black at the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1        <= 1'b0;
      vs1        <= 1'b0;
      de1        <= 1'b0;
      pix1       <= '0;
      vid.out_hs <= 1'b0;
      vid.out_vs <= 1'b0;
      vid.out_de <= 1'b0;
      vid.out_r  <= 8'd0;
      vid.out_g  <= 8'd0;
      vid.out_b  <= 8'd0;
    end else begin
      hs1        <= vid.in_hs;
      vs1        <= vid.in_vs;
      de1        <= vid.in_de;
      pix1       <= pix_sel;
      vid.out_hs <= hs1;
      vid.out_vs <= vs1;
      vid.out_de <= de1;
      {vid.out_r, vid.out_g, vid.out_b} <= de1 ? pix1 : 24'd0;
    end
  end

endmodule
